// File: rtl/io_hub.sv
// Memory-mapped IO hub: GPIO out/in registers plus a FIFO-fed 8N1 UART transmitter.
// Register select is one-hot on word_addr; read data is registered and held between reads.
module io_hub #(
  parameter int CLK_FREQ_HZ = 12000000,
  parameter int BAUD_RATE   = 115200,
  parameter int FIFO_DEPTH  = 16,
  parameter int N_OUT       = 8,
  parameter int N_IN        = 8,
  parameter int OUT_INVERT  = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             sel,
  input  logic [3:0]       word_addr,
  input  logic [31:0]      wdata,
  input  logic             wstrb,
  input  logic             rstrb,
  output logic [31:0]      rdata,
  input  logic [N_IN-1:0]  gpio_in,
  output logic [N_OUT-1:0] gpio_out,
  output logic             tx
);

  localparam int DIV = CLK_FREQ_HZ / BAUD_RATE;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam logic [N_OUT-1:0] INV = (OUT_INVERT != 0) ? {N_OUT{1'b1}} : {N_OUT{1'b0}};

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic wr, rd;
  assign wr = sel & wstrb;
  assign rd = sel & rstrb;

  // ---------------- GPIO ----------------
  logic [N_IN-1:0] sync1, sync2;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= gpio_in;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                  gpio_out <= INV;
    else if (wr && word_addr[0]) gpio_out <= wdata[N_OUT-1:0] ^ INV;
  end

  // ---------------- TX FIFO ----------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, empty, push_req, push, drop, pop, overflow;

  assign full     = (count == (AW+1)'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign push_req = wr & word_addr[1];
  // Full is judged before the edge, so a push racing a pop on a full FIFO is still lost.
  assign push     = push_req & ~full;
  assign drop     = push_req & full;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata[7:0];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                                   overflow <= 1'b0;
    else if (drop)                               overflow <= 1'b1;
    else if (wr && word_addr[2] && wdata[0])     overflow <= 1'b0;
  end

  // ---------------- TX serializer ----------------
  state_t        state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          bit_end;

  assign bit_end = (baud_cnt == CW'(DIV - 1));
  // Must mirror the FSM's load conditions exactly; the FSM consumes mem[rd_ptr] on these edges.
  assign pop     = ~empty & ((state == IDLE) | ((state == STOP) & bit_end));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (!empty) begin
            state    <= START;
            baud_cnt <= '0;
            shreg    <= mem[rd_ptr];
            tx       <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            state    <= DATA;
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= shreg[0];
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shreg   <= shreg >> 1;
              tx      <= shreg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (!empty) begin
              state <= START;
              shreg <= mem[rd_ptr];
              tx    <= 1'b0;
            end else begin
              state <= IDLE;
              tx    <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          baud_cnt <= '0;
          tx       <= 1'b1;
        end
      endcase
    end
  end

  // ---------------- Read path ----------------
  logic [31:0] count32, status;
  logic [7:0]  level;
  logic        busy;

  assign count32 = 32'(count);
  assign level   = (count32 > 32'd255) ? 8'hFF : count32[7:0];
  assign busy    = ~empty | (state != IDLE);
  assign status  = {21'b0, overflow, full, busy, level};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdata <= '0;
    end else if (rd) begin
      if (word_addr[2])      rdata <= status;
      else if (word_addr[3]) rdata <= 32'(sync2);
      else if (word_addr[0]) rdata <= 32'(gpio_out ^ INV);
      else                   rdata <= '0;
    end
  end

  logic unused;
  assign unused = &{1'b0, wdata};

endmodule

// File: tb/tb_io_hub.sv
// Self-checking bench for io_hub: register model plus a bit-level UART receiver model.
module tb_io_hub;
  localparam int CLK_HZ = 12000000;
  localparam int BAUD   = 115200;
  localparam int DIV    = CLK_HZ / BAUD;
  localparam int DEPTH  = 16;
  localparam int NO     = 8;
  localparam int NI     = 8;

  logic          clk = 1'b0, rstn = 1'b0, sel = 1'b0, wstrb = 1'b0, rstrb = 1'b0;
  logic [3:0]    word_addr = '0;
  logic [31:0]   wdata = '0;
  logic [31:0]   rdata;
  logic [NI-1:0] gpio_in = '0;
  logic [NO-1:0] gpio_out;
  logic          tx;

  int cmp = 0, err = 0, cyc = 0;
  logic [7:0] rx_q[$];
  int         rx_t[$];

  io_hub #(.CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD), .FIFO_DEPTH(DEPTH),
           .N_OUT(NO), .N_IN(NI), .OUT_INVERT(1)) dut (
    .clk(clk), .rstn(rstn), .sel(sel), .word_addr(word_addr), .wdata(wdata),
    .wstrb(wstrb), .rstrb(rstrb), .rdata(rdata), .gpio_in(gpio_in),
    .gpio_out(gpio_out), .tx(tx));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // UART receiver: samples mid-bit, records byte and start cycle; frames hit by reset are discarded.
  int         t0;
  bit         ok;
  logic [7:0] rb;
  logic       sb;
  initial begin : rx_model
    forever begin
      @(negedge clk);
      if (rstn === 1'b1 && tx === 1'b0) begin
        t0 = cyc; ok = 1'b1; rb = '0; sb = 1'b0;
        for (int c = 1; c <= 9*DIV + DIV/2; c++) begin
          @(negedge clk);
          if (rstn !== 1'b1) ok = 1'b0;
          if (c == DIV/2 && tx !== 1'b0) ok = 1'b0;
          if (c > DIV && c < 9*DIV && (c - DIV/2) % DIV == 0) rb[(c - DIV/2)/DIV - 1] = tx;
          if (c == 9*DIV + DIV/2) sb = tx;
        end
        if (ok) begin
          cmp++;
          if (sb !== 1'b1) begin
            err++; $display("FAIL rx_stop_bit: got %b want 1", sb);
          end else begin
            rx_q.push_back(rb); rx_t.push_back(t0);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // All bus tasks start and end at a falling edge.
  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    sel = 1'b1; wstrb = 1'b1; word_addr = a; wdata = d;
    @(negedge clk);
    sel = 1'b0; wstrb = 1'b0; word_addr = '0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    sel = 1'b1; rstrb = 1'b1; word_addr = a;
    @(negedge clk);
    sel = 1'b0; rstrb = 1'b0; word_addr = '0;
    d = rdata;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rstn = 1'b0;
    #7;
    cmp++; if (tx !== 1'b1) begin err++; $display("FAIL reset_tx: got %b want 1", tx); end
    cmp++; if (gpio_out !== 8'hFF) begin err++; $display("FAIL reset_gpio_out: got %h want ff", gpio_out); end
    cmp++; if (rdata !== 32'h0) begin err++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    @(negedge clk);
    rstn = 1'b1;
    rd(4'b0100, d);
    cmp++; if (d !== 32'h0) begin err++; $display("FAIL reset_status: got %h want 0", d); end
    rd(4'b0001, d);
    cmp++; if (d !== 32'h0) begin err++; $display("FAIL reset_gpio_rb: got %h want 0", d); end
  endtask

  task automatic test_gpio_out();
    logic [31:0] d, v;
    logic [7:0]  pins;
    wr(4'b0001, 32'h000000A5);
    cmp++; if (gpio_out !== 8'h5A) begin err++; $display("FAIL gpio_out_a5: got %h want 5a", gpio_out); end
    rd(4'b0001, d);
    cmp++; if (d !== 32'h000000A5) begin err++; $display("FAIL gpio_rb_a5: got %h want a5", d); end
    for (int i = 0; i < 6; i++) begin
      v = $urandom;
      wr(4'b0001, v);
      pins = v[7:0] ^ 8'hFF;
      cmp++; if (gpio_out !== pins) begin err++; $display("FAIL gpio_out_rand: got %h want %h", gpio_out, pins); end
      rd(4'b0001, d);
      cmp++; if (d !== {24'h0, v[7:0]}) begin err++; $display("FAIL gpio_rb_rand: got %h want %h", d, v[7:0]); end
    end
    // Strobe without sel must be ignored.
    wstrb = 1'b1; word_addr = 4'b0001; wdata = ~v;
    @(negedge clk);
    wstrb = 1'b0; word_addr = '0;
    cmp++; if (gpio_out !== pins) begin err++; $display("FAIL gpio_no_sel: got %h want %h", gpio_out, pins); end
  endtask

  task automatic test_gpio_in();
    logic [31:0] d;
    logic [7:0]  v;
    gpio_in = 8'h11;
    repeat (3) @(negedge clk);
    gpio_in = 8'h3C;
    @(negedge clk);
    rd(4'b1000, d);
    cmp++; if (d !== 32'h11) begin err++; $display("FAIL gpio_in_1edge: got %h want 11", d); end
    rd(4'b1000, d);
    cmp++; if (d !== 32'h3C) begin err++; $display("FAIL gpio_in_2edge: got %h want 3c", d); end
    for (int i = 0; i < 6; i++) begin
      v = 8'($urandom_range(0, 255));
      gpio_in = v;
      repeat (2) @(negedge clk);
      rd(4'b1000, d);
      cmp++; if (d !== {24'h0, v}) begin err++; $display("FAIL gpio_in_rand: got %h want %h", d, v); end
    end
  endtask

  task automatic test_read_mux();
    logic [31:0] d;
    gpio_in = 8'h96;
    wr(4'b0001, 32'h3C);
    repeat (2) @(negedge clk);
    rd(4'b1111, d);
    cmp++; if (d !== 32'h0) begin err++; $display("FAIL mux_status_first: got %h want 0", d); end
    rd(4'b1001, d);
    cmp++; if (d !== 32'h96) begin err++; $display("FAIL mux_in_over_out: got %h want 96", d); end
    rd(4'b0011, d);
    cmp++; if (d !== 32'h3C) begin err++; $display("FAIL mux_out: got %h want 3c", d); end
    rd(4'b0010, d);
    cmp++; if (d !== 32'h0) begin err++; $display("FAIL mux_dat_only: got %h want 0", d); end
    rd(4'b1000, d);
    gpio_in = 8'h01;
    repeat (4) @(negedge clk);
    cmp++; if (rdata !== 32'h96) begin err++; $display("FAIL rdata_hold: got %h want 96", rdata); end
    rd(4'b0000, d);
    cmp++; if (d !== 32'h0) begin err++; $display("FAIL mux_none: got %h want 0", d); end
  endtask

  task automatic test_uart_frame();
    logic [7:0] b;
    logic       exp_tx;
    int         bi;
    b = 8'h55;
    rx_q.delete(); rx_t.delete();
    wr(4'b0010, {24'h0, b});
    sel = 1'b1; rstrb = 1'b1; word_addr = 4'b0100;
    for (int k = 0; k < 10*DIV; k++) begin
      @(negedge clk);
      bi = k / DIV;
      exp_tx = (bi == 0) ? 1'b0 : (bi <= 8) ? b[bi-1] : 1'b1;
      cmp++; if (tx !== exp_tx) begin err++; $display("FAIL frame_tx k=%0d: got %b want %b", k, tx, exp_tx); end
      cmp++; if (rdata[8] !== 1'b1) begin err++; $display("FAIL frame_busy k=%0d: got %b want 1", k, rdata[8]); end
    end
    repeat (3) @(negedge clk);
    cmp++; if (rdata !== 32'h0) begin err++; $display("FAIL frame_idle_status: got %h want 0", rdata); end
    cmp++; if (tx !== 1'b1) begin err++; $display("FAIL frame_idle_tx: got %b want 1", tx); end
    sel = 1'b0; rstrb = 1'b0; word_addr = '0;
    cmp++; if (rx_q.size() != 1 || rx_q[0] !== b) begin
      err++; $display("FAIL frame_rx: got %0d bytes want 1 byte %h", rx_q.size(), b);
    end
  endtask

  task automatic test_overflow();
    logic [7:0]  exp_q[$];
    logic [7:0]  v;
    logic [31:0] d, e;
    int          lvl;
    bit          ovf;
    rx_q.delete(); rx_t.delete();
    v = 8'($urandom);
    exp_q.push_back(v);
    wr(4'b0010, {24'h0, v});
    repeat (3) @(negedge clk);       // first byte now in the serializer
    lvl = 0; ovf = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      v = 8'($urandom);
      wr(4'b0010, {24'h0, v});
      if (lvl < DEPTH) begin exp_q.push_back(v); lvl++; end
      else ovf = 1'b1;
    end
    rd(4'b0100, d);
    e = (32'(ovf) << 10) | (32'(lvl == DEPTH) << 9) | (32'h1 << 8) | 32'(lvl);
    cmp++; if (d !== e) begin err++; $display("FAIL ovf_status: got %h want %h", d, e); end
    wr(4'b0100, 32'h1); ovf = 1'b0;
    rd(4'b0100, d);
    e = (32'(ovf) << 10) | (32'(lvl == DEPTH) << 9) | (32'h1 << 8) | 32'(lvl);
    cmp++; if (d !== e) begin err++; $display("FAIL ovf_clear: got %h want %h", d, e); end
    wr(4'b0110, 32'h1);                 // dropped push and clear together
    if (lvl == DEPTH) ovf = 1'b1;
    rd(4'b0100, d);
    e = (32'(ovf) << 10) | (32'(lvl == DEPTH) << 9) | (32'h1 << 8) | 32'(lvl);
    cmp++; if (d !== e) begin err++; $display("FAIL ovf_set_wins: got %h want %h", d, e); end
    wr(4'b0100, 32'h1);
    for (int i = 0; i < 25000 && rx_q.size() < exp_q.size(); i++) @(negedge clk);
    cmp++; if (rx_q.size() != exp_q.size()) begin
      err++; $display("FAIL ovf_rx_count: got %0d want %0d", rx_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        cmp++; if (rx_q[i] !== exp_q[i]) begin err++; $display("FAIL ovf_rx_byte %0d: got %h want %h", i, rx_q[i], exp_q[i]); end
      end
      for (int i = 0; i + 1 < rx_t.size(); i++) begin
        cmp++; if (rx_t[i+1] - rx_t[i] != 10*DIV) begin
          err++; $display("FAIL ovf_rx_gap %0d: got %0d want %0d", i, rx_t[i+1] - rx_t[i], 10*DIV);
        end
      end
    end
    repeat (DIV) @(negedge clk);
    rd(4'b0100, d);
    cmp++; if (d !== 32'h0) begin err++; $display("FAIL ovf_drained: got %h want 0", d); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0]  b1;
    logic [31:0] d;
    int          lows;
    rx_q.delete(); rx_t.delete();
    wr(4'b0001, 32'h0F);
    b1 = 8'($urandom);
    wr(4'b0010, {24'h0, b1});
    wr(4'b0010, 32'($urandom_range(0, 255)));
    wr(4'b0010, 32'($urandom_range(0, 255)));
    repeat (4*DIV + DIV/2 - 1) @(negedge clk);   // middle of data bit 3
    cmp++; if (tx !== b1[3]) begin err++; $display("FAIL mid_bit3: got %b want %b", tx, b1[3]); end
    #2 rstn = 1'b0;
    #1;
    cmp++; if (tx !== 1'b1) begin err++; $display("FAIL rst_async_tx: got %b want 1", tx); end
    cmp++; if (gpio_out !== 8'hFF) begin err++; $display("FAIL rst_async_gpio: got %h want ff", gpio_out); end
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    rd(4'b0100, d);
    cmp++; if (d !== 32'h0) begin err++; $display("FAIL rst_status: got %h want 0", d); end
    lows = 0;
    for (int i = 0; i < 25*DIV; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    cmp++; if (lows != 0) begin err++; $display("FAIL rst_no_frames: got %0d low cycles want 0", lows); end
    cmp++; if (rx_q.size() != 0) begin err++; $display("FAIL rst_rx_count: got %0d want 0", rx_q.size()); end
  endtask

  initial begin
    test_reset();
    test_gpio_out();
    test_gpio_in();
    test_read_mux();
    test_uart_frame();
    test_overflow();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end

endmodule
